// File: rtl/wb_pkg.sv
// Shared types and width helpers for the Wishbone B4 pipelined 1:N address decoder.
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR_PEND
  } wb_dec_state_e;

  // Width of a counter that must hold the values 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/wb_out_tracker.sv
// Outstanding-request counter with full detection; the hung-slave watchdog
// is built only when WB_TIMEOUT_EN is defined.
module wb_out_tracker
  import wb_pkg::*;
#(
  parameter int MAX_OUT = 4
`ifdef WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept_i,
  input  logic retire_i,
  input  logic clear_i,
  output logic pending_o,
  output logic last_o,
  output logic full_o,
  output logic timeout_o
);

  localparam int CNT_W = cnt_w(MAX_OUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_eff;
  logic             timeout;

  assign pending_o  = (cnt_q != '0);
  assign last_o     = (cnt_q == CNT_W'(1));
  assign full_o     = (cnt_q == CNT_W'(MAX_OUT));
  // A response with nothing outstanding is spurious and must not underflow.
  assign retire_eff = retire_i && pending_o;
  assign timeout_o  = timeout;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || timeout) begin
      cnt_d = '0;
    end else if (accept_i && !retire_eff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept_i && retire_eff) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  assign timeout = (wd_q == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    wd_d = wd_q + WD_W'(1);
    if (clear_i || retire_eff || !pending_o || timeout) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/wb_decoder.sv
// Wishbone B4 pipelined 1-master-to-N-slave decoder and response router.
// Optional hung-slave watchdog is enabled with the WB_TIMEOUT_EN macro.
module wb_decoder
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int SEL_W          = 3,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m_i_cyc,
  input  logic                         m_i_stb,
  input  logic                         m_i_we,
  input  logic [ADDR_W-1:0]            m_i_addr,
  input  logic [DATA_W-1:0]            m_i_data,
  input  logic [DATA_W/8-1:0]          m_i_sel,
  output logic                         m_o_stall,
  output logic                         m_o_ack,
  output logic                         m_o_err,
  output logic [DATA_W-1:0]            m_o_data,
  output logic [NUM_SLAVES-1:0]        s_o_cyc,
  output logic [NUM_SLAVES-1:0]        s_o_stb,
  output logic                         s_o_we,
  output logic [ADDR_W-1:0]            s_o_addr,
  output logic [DATA_W-1:0]            s_o_data,
  output logic [DATA_W/8-1:0]          s_o_sel,
  input  logic [NUM_SLAVES-1:0]        s_i_stall,
  input  logic [NUM_SLAVES-1:0]        s_i_ack,
  input  logic [NUM_SLAVES-1:0]        s_i_err,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_i_data
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > (2 ** SEL_W) || MAX_OUT < 1 ||
      TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_bad_cfg
    $error("wb_decoder: illegal parameter combination");
  end

  wb_dec_state_e     state_q;
  logic [SEL_W-1:0]  lock_q;
  logic [SEL_W-1:0]  idx;
  logic              mapped, cyc, stall, accept;
  logic              tgt_stall, lock_ack, lock_err;
  logic [DATA_W-1:0] lock_data;
  logic              pending, last, full, timeout;

  // Reset is folded into the combinational outputs so they all read 0 while rst_n is low.
  assign cyc    = m_i_cyc && rst_n;
  assign idx    = m_i_addr[ADDR_W-1 -: SEL_W];
  assign mapped = (int'(idx) < NUM_SLAVES);

  always_comb begin
    tgt_stall = 1'b0;
    lock_ack  = 1'b0;
    lock_err  = 1'b0;
    lock_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx == SEL_W'(k)) tgt_stall = s_i_stall[k];
      if (lock_q == SEL_W'(k)) begin
        lock_ack  = s_i_ack[k];
        lock_err  = s_i_err[k];
        lock_data = s_i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign stall = rst_n && (full || (state_q == BUSY && idx != lock_q) || tgt_stall ||
                           state_q == ERR_PEND || (!mapped && pending) || timeout);
  assign accept = cyc && m_i_stb && !stall;

  always_comb begin
    s_o_cyc = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      s_o_cyc[k] = cyc && !timeout &&
                   ((state_q == BUSY && lock_q == SEL_W'(k)) ||
                    (state_q == IDLE && idx == SEL_W'(k)));
    end
  end

  assign s_o_stb   = s_o_cyc & {NUM_SLAVES{m_i_stb && !stall}};
  assign s_o_we    = m_i_we && rst_n;
  assign s_o_addr  = rst_n ? m_i_addr : '0;
  assign s_o_data  = rst_n ? m_i_data : '0;
  assign s_o_sel   = rst_n ? m_i_sel  : '0;

  assign m_o_stall = stall;
  assign m_o_ack   = cyc && pending && lock_ack;
  assign m_o_err   = (state_q == ERR_PEND) || (cyc && pending && lock_err) || timeout;
  assign m_o_data  = rst_n ? lock_data : '0;

  wb_out_tracker #(
    .MAX_OUT(MAX_OUT)
`ifdef WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept_i (accept && mapped),
    .retire_i (cyc && (lock_ack || lock_err)),
    .clear_i  (!cyc),
    .pending_o(pending),
    .last_o   (last),
    .full_o   (full),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (mapped) begin
              state_q <= BUSY;
              lock_q  <= idx;
            end else begin
              state_q <= ERR_PEND;
            end
          end
        end
        BUSY: begin
          if (!cyc || timeout ||
              (!accept && (!pending || (last && (lock_ack || lock_err))))) begin
            state_q <= IDLE;
          end
        end
        ERR_PEND: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_decoder.sv
// Directed-vector bench for wb_decoder with a response scoreboard.
module tb_wb_decoder;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_i_cyc, m_i_stb, m_i_we;
  logic [AW-1:0]    m_i_addr;
  logic [DW-1:0]    m_i_data;
  logic [DW/8-1:0]  m_i_sel;
  logic             m_o_stall, m_o_ack, m_o_err;
  logic [DW-1:0]    m_o_data;
  logic [NS-1:0]    s_o_cyc, s_o_stb;
  logic             s_o_we;
  logic [AW-1:0]    s_o_addr;
  logic [DW-1:0]    s_o_data;
  logic [DW/8-1:0]  s_o_sel;
  logic [NS-1:0]    s_i_stall, s_i_ack, s_i_err;
  logic [NS*DW-1:0] s_i_data;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_decoder #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_W(3), .MAX_OUT(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_i_cyc(m_i_cyc), .m_i_stb(m_i_stb), .m_i_we(m_i_we), .m_i_addr(m_i_addr),
    .m_i_data(m_i_data), .m_i_sel(m_i_sel),
    .m_o_stall(m_o_stall), .m_o_ack(m_o_ack), .m_o_err(m_o_err), .m_o_data(m_o_data),
    .s_o_cyc(s_o_cyc), .s_o_stb(s_o_stb), .s_o_we(s_o_we), .s_o_addr(s_o_addr),
    .s_o_data(s_o_data), .s_o_sel(s_o_sel),
    .s_i_stall(s_i_stall), .s_i_ack(s_i_ack), .s_i_err(s_i_err), .s_i_data(s_i_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    m_i_cyc  = c;
    m_i_stb  = s;
    m_i_we   = w;
    m_i_addr = a;
    m_i_data = d;
  endtask

  task automatic set_sdata(input int k, input logic [31:0] v);
    s_i_data[k*DW +: DW] = v;
  endtask

  task automatic expect_rsp(input logic err, input logic chk, input logic [31:0] d);
    rsp_t r;
    r.err      = err;
    r.chk_data = chk;
    r.data     = d;
    exp_q.push_back(r);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (m_o_ack || m_o_err) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got ack=%0b err=%0b data=%h expected no response",
                 m_o_ack, m_o_err, m_o_data);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        if (m_o_ack !== !e.err || m_o_err !== e.err || (e.chk_data && m_o_data !== e.data)) begin
          n_err++;
          $display("FAIL rsp_compare: got ack=%0b err=%0b data=%h expected ack=%0b err=%0b data=%h",
                   m_o_ack, m_o_err, m_o_data, !e.err, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    drive(0, 0, 0, 0, 0);
    m_i_sel   = 4'hF;
    s_i_stall = '0;
    s_i_ack   = '0;
    s_i_err   = '0;
    s_i_data  = '0;
    set_sdata(0, 32'h0000_A000);
    set_sdata(1, 32'h1111_1111);
    set_sdata(3, 32'h3333_3333);
    #12;
    check("rst_stall", 32'(m_o_stall), 0);
    check("rst_ack",   32'(m_o_ack),   0);
    check("rst_err",   32'(m_o_err),   0);
    check("rst_cyc",   32'(s_o_cyc),   0);
    check("rst_stb",   32'(s_o_stb),   0);
    #1 rst_n = 1'b1;
    next_cycle();

    // Single read from slave 2.
    drive(1, 1, 0, 32'h4000_0010, 0);
    @(negedge clk);
    check("t1_stb",   32'(s_o_stb), 'h4);
    check("t1_cyc",   32'(s_o_cyc), 'h4);
    check("t1_stall", 32'(m_o_stall), 0);
    check("t1_addr",  s_o_addr, 32'h4000_0010);
    check("t1_sel",   32'(s_o_sel), 'hF);
    next_cycle();
    drive(1, 0, 0, 32'h4000_0010, 0);
    set_sdata(2, 32'hDEAD_BEEF);
    s_i_ack = 4'b0100;
    expect_rsp(0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_ack",  32'(m_o_ack), 1);
    check("t1_data", m_o_data, 32'hDEAD_BEEF);
    check("t1_stb_off", 32'(s_o_stb), 0);
    next_cycle();
    drive(1, 0, 0, 32'h0000_0000, 0);
    @(negedge clk);
    check("t1_idle_cyc", 32'(s_o_cyc), 'h1);
    check("t1_spurious_ack", 32'(m_o_ack), 0);
    next_cycle();
    s_i_ack = '0;

    // Four pipelined writes to slave 1, ack withheld until the window is full.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 32'h2000_0000 + 32'(4 * i), 32'hA0 + 32'(i));
      @(negedge clk);
      check("t2_stb", 32'(s_o_stb), 'h2);
      check("t2_stall", 32'(m_o_stall), 0);
      if (i == 0) check("t2_wdata", s_o_data, 32'hA0);
      next_cycle();
    end
    drive(1, 1, 1, 32'h2000_0010, 32'hA4);
    @(negedge clk);
    check("t2_full_stall", 32'(m_o_stall), 1);
    check("t2_full_stb", 32'(s_o_stb), 0);
    next_cycle();
    s_i_ack = 4'b0010;
    expect_rsp(0, 0, 0);
    @(negedge clk);
    check("t2_full_stall_ack", 32'(m_o_stall), 1);
    next_cycle();
    expect_rsp(0, 0, 0);
    @(negedge clk);
    check("t2_ack_plus_stb_stall", 32'(m_o_stall), 0);
    check("t2_ack_plus_stb", 32'(s_o_stb), 'h2);
    next_cycle();
    drive(1, 0, 1, 32'h2000_0010, 32'hA4);
    for (int i = 0; i < 3; i++) begin
      expect_rsp(0, 0, 0);
      next_cycle();
    end
    @(negedge clk);
    check("t2_drained", 32'(m_o_ack), 0);
    next_cycle();
    s_i_ack = '0;

    // Switch from slave 3 to slave 0 waits for drain.
    drive(1, 1, 0, 32'h6000_0004, 0);
    @(negedge clk);
    check("t3_stb3", 32'(s_o_stb), 'h8);
    next_cycle();
    drive(1, 1, 0, 32'h0000_0008, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_switch_stall", 32'(m_o_stall), 1);
      check("t3_switch_stb", 32'(s_o_stb), 0);
      next_cycle();
    end
    set_sdata(3, 32'hCAFE_0003);
    s_i_ack = 4'b1000;
    expect_rsp(0, 1, 32'hCAFE_0003);
    @(negedge clk);
    check("t3_stall_drain", 32'(m_o_stall), 1);
    next_cycle();
    s_i_ack = '0;
    @(negedge clk);
    check("t3_after_drain_stall", 32'(m_o_stall), 0);
    check("t3_after_drain_stb", 32'(s_o_stb), 'h1);
    next_cycle();
    drive(1, 0, 0, 32'h0000_0008, 0);
    set_sdata(0, 32'h0BAD_F00D);
    s_i_ack = 4'b0001;
    expect_rsp(0, 1, 32'h0BAD_F00D);
    next_cycle();
    s_i_ack = '0;

    // Unmapped address (index 7).
    drive(1, 1, 0, 32'hE000_0000, 0);
    expect_rsp(1, 0, 0);
    @(negedge clk);
    check("t4_stb", 32'(s_o_stb), 0);
    check("t4_cyc", 32'(s_o_cyc), 0);
    check("t4_stall", 32'(m_o_stall), 0);
    check("t4_err_early", 32'(m_o_err), 0);
    next_cycle();
    drive(1, 0, 0, 32'hE000_0000, 0);
    @(negedge clk);
    check("t4_err", 32'(m_o_err), 1);
    check("t4_no_ack", 32'(m_o_ack), 0);
    check("t4_errpend_stall", 32'(m_o_stall), 1);
    next_cycle();
    @(negedge clk);
    check("t4_err_once", 32'(m_o_err), 0);
    next_cycle();

    // Cycle dropped with two reads outstanding, then late acks.
    drive(1, 1, 0, 32'h2000_0000, 0);
    next_cycle();
    next_cycle();
    drive(0, 0, 0, 32'h2000_0000, 0);
    next_cycle();
    s_i_ack = 4'b0010;
    @(negedge clk);
    check("t5_late_ack_nocyc", 32'(m_o_ack), 0);
    next_cycle();
    drive(1, 0, 0, 32'h2000_0000, 0);
    @(negedge clk);
    check("t5_late_ack", 32'(m_o_ack), 0);
    check("t5_idle_cyc", 32'(s_o_cyc), 'h2);
    next_cycle();
    s_i_ack = '0;

    // Reset mid-burst.
    drive(1, 1, 0, 32'h2000_0000, 0);
    next_cycle();
    s_i_ack = 4'b0010;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_cyc",   32'(s_o_cyc), 0);
    check("t5_rst_stb",   32'(s_o_stb), 0);
    check("t5_rst_stall", 32'(m_o_stall), 0);
    check("t5_rst_ack",   32'(m_o_ack), 0);
    check("t5_rst_err",   32'(m_o_err), 0);
    check("t5_rst_addr",  s_o_addr, 0);
    check("t5_rst_data",  m_o_data, 0);
    drive(1, 0, 0, 32'h2000_0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("t5_post_rst_ack", 32'(m_o_ack), 0);
    check("t5_post_rst_cyc", 32'(s_o_cyc), 'h2);
    next_cycle();
    s_i_ack = '0;

`ifdef WB_TIMEOUT_EN
    // Watchdog: slave 2 never answers.
    drive(1, 1, 0, 32'h4000_0000, 0);
    next_cycle();
    drive(1, 0, 0, 32'h4000_0000, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_err_yet", 32'(m_o_err), 0);
      next_cycle();
    end
    expect_rsp(1, 0, 0);
    @(negedge clk);
    check("t6_timeout_err", 32'(m_o_err), 1);
    check("t6_timeout_cyc", 32'(s_o_cyc), 0);
    next_cycle();
    drive(1, 1, 0, 32'h4000_0000, 0);
    @(negedge clk);
    check("t6_reaccept_stall", 32'(m_o_stall), 0);
    check("t6_reaccept_stb", 32'(s_o_stb), 'h4);
    next_cycle();
    drive(1, 0, 0, 32'h4000_0000, 0);
    set_sdata(2, 32'h0000_0B0B);
    s_i_ack = 4'b0100;
    expect_rsp(0, 1, 32'h0000_0B0B);
    next_cycle();
    s_i_ack = '0;
`endif

    drive(0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
